// File: rtl/rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_fade_sequencer
//  Description : Steps R/G/B PWM duty values between four fixed colour
//                presets, fading at most 1 LSB per channel per fade tick.
//                Manual mode follows the switches; auto mode advances on a
//                dwell timer or on a debounced button press.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_fade_sequencer #(
    parameter int TICK_DIV     = 50000,
    parameter int DWELL_TICKS  = 256,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       auto_en,
    input  logic [1:0] sw,
    input  logic       btn_next,
    output logic [7:0] R_duty,
    output logic [7:0] G_duty,
    output logic [7:0] B_duty,
    output logic [1:0] preset_idx,
    output logic       busy
);

    localparam int c_TICK_W  = $clog2(TICK_DIV);
    localparam int c_DWELL_W = $clog2(DWELL_TICKS + 1);
    localparam int c_DEB_W   = $clog2(DEBOUNCE_CYC);

    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL_TICKS - 1);
    localparam logic [c_DEB_W-1:0]   c_DEB_LAST   = c_DEB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [0:0] {
        ST_FADE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_idx, w_idx_nxt;
    logic [c_DWELL_W-1:0]  r_dwell, w_dwell_nxt;
    logic [7:0]            r_r, r_g, r_b;
    logic [7:0]            w_r_nxt, w_g_nxt, w_b_nxt;

    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic                  w_tick;

    logic                  r_sync1, r_sync2;
    logic                  r_db_level;
    logic [c_DEB_W-1:0]    r_db_cnt;
    logic                  r_btn_pulse;
    logic                  w_db_flip;

    logic [23:0]           w_tgt;
    logic                  w_at_target;

    // Fixed colour preset table, packed as {R, G, B}
    function automatic logic [23:0] preset_rgb(input logic [1:0] idx);
        case (idx)
            2'd0:    preset_rgb = 24'h9932CC;
            2'd1:    preset_rgb = 24'h1E90FF;
            2'd2:    preset_rgb = 24'hFFD700;
            default: preset_rgb = 24'hFF2D00;
        endcase
    endfunction

    // One LSB toward the target; never passes it, so 00/FF cannot wrap
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)
            step_toward = cur + 8'd1;
        else if (cur > tgt)
            step_toward = cur - 8'd1;
        else
            step_toward = cur;
    endfunction

    assign w_tick      = (r_tick_cnt == c_TICK_LAST);
    assign w_tgt       = preset_rgb(r_idx);
    assign w_at_target = (r_r == w_tgt[23:16]) && (r_g == w_tgt[15:8]) && (r_b == w_tgt[7:0]);
    assign w_db_flip   = (r_sync2 != r_db_level) && (r_db_cnt == c_DEB_LAST);

    // Free-running fade tick divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // Button: two-flop synchronizer, stability counter, rising-edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_db_level  <= 1'b0;
            r_db_cnt    <= '0;
            r_btn_pulse <= 1'b0;
        end else begin
            r_sync1     <= btn_next;
            r_sync2     <= r_sync1;
            r_btn_pulse <= w_db_flip && r_sync2;
            if (r_sync2 == r_db_level)
                r_db_cnt <= '0;
            else if (w_db_flip) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else
                r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Sequencer state, target index, dwell timer and duty registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FADE;
            r_idx   <= 2'd0;
            r_dwell <= '0;
            r_r     <= 8'h00;
            r_g     <= 8'h00;
            r_b     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_dwell <= w_dwell_nxt;
            r_r     <= w_r_nxt;
            r_g     <= w_g_nxt;
            r_b     <= w_b_nxt;
        end
    end

    // Next-state: fade stepping, retargeting and dwell-driven advance
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_dwell_nxt = r_dwell;
        w_r_nxt     = r_r;
        w_g_nxt     = r_g;
        w_b_nxt     = r_b;

        // Stepping always aims at the current target; a retarget this cycle
        // takes effect from the next tick onward without disturbing values.
        if (r_state == ST_FADE && w_tick) begin
            w_r_nxt = step_toward(r_r, w_tgt[23:16]);
            w_g_nxt = step_toward(r_g, w_tgt[15:8]);
            w_b_nxt = step_toward(r_b, w_tgt[7:0]);
        end

        if (!auto_en) begin
            w_dwell_nxt = '0;
            if (sw != r_idx) begin
                w_idx_nxt   = sw;
                w_state_nxt = ST_FADE;
            end else if (r_state == ST_FADE && w_at_target) begin
                w_state_nxt = ST_HOLD;
            end
        end else if (r_btn_pulse) begin
            // Button wins over a coincident dwell expiry: one advance only
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = ST_FADE;
            w_dwell_nxt = '0;
        end else if (r_state == ST_HOLD) begin
            if (w_tick) begin
                if (r_dwell == c_DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = ST_FADE;
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
        end else if (w_at_target) begin
            w_state_nxt = ST_HOLD;
        end
    end

    assign R_duty     = r_r;
    assign G_duty     = r_g;
    assign B_duty     = r_b;
    assign preset_idx = r_idx;
    assign busy       = (r_state == ST_FADE);

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_fade_sequencer
//  Description : Self-checking bench for rgb_fade_sequencer: directed vector
//                table, hand-built corner sequences and randomized stimulus
//                compared against a behavioural colour-fade model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_fade_sequencer;

    localparam int TICK_DIV     = 4;
    localparam int DWELL_TICKS  = 8;
    localparam int DEBOUNCE_CYC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       auto_en = 1'b0;
    logic [1:0] sw = 2'd0;
    logic       btn_next = 1'b0;
    logic [7:0] R_duty, G_duty, B_duty;
    logic [1:0] preset_idx;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    rgb_fade_sequencer #(
        .TICK_DIV     (TICK_DIV),
        .DWELL_TICKS  (DWELL_TICKS),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .auto_en    (auto_en),
        .sw         (sw),
        .btn_next   (btn_next),
        .R_duty     (R_duty),
        .G_duty     (G_duty),
        .B_duty     (B_duty),
        .preset_idx (preset_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int PR [4] = '{'h99, 'h1E, 'hFF, 'hFF};
    int PG [4] = '{'h32, 'h90, 'hD7, 'h2D};
    int PB [4] = '{'hCC, 'hFF, 'h00, 'h00};

    int m_r, m_g, m_b, m_idx, m_dwell, m_cyc;
    bit m_fading, m_level, m_pulse;
    bit raw_q[$];
    bit sync_q[$];

    function automatic int toward(input int cur, input int tgt);
        if (tgt > cur) return cur + 1;
        if (tgt < cur) return cur - 1;
        return cur;
    endfunction

    task automatic model_reset();
        m_r = 0; m_g = 0; m_b = 0; m_idx = 0; m_dwell = 0; m_cyc = 0;
        m_fading = 1'b1; m_level = 1'b0; m_pulse = 1'b0;
        raw_q.delete();
        sync_q.delete();
    endtask

    // Advance the model by one clock edge with the inputs present at that edge
    task automatic model_edge(input bit a, input int s, input bit b);
        bit tick;
        bit pulse;
        bit reached;
        bit s2;
        bit all_diff;
        bit np;
        tick    = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
        pulse   = m_pulse;
        reached = m_fading && m_r == PR[m_idx] && m_g == PG[m_idx] && m_b == PB[m_idx];
        if (m_fading && tick) begin
            m_r = toward(m_r, PR[m_idx]);
            m_g = toward(m_g, PG[m_idx]);
            m_b = toward(m_b, PB[m_idx]);
        end
        if (!a) begin
            m_dwell = 0;
            if (s != m_idx) begin
                m_idx = s;
                m_fading = 1'b1;
            end else if (reached) begin
                m_fading = 1'b0;
            end
        end else if (pulse) begin
            m_idx = (m_idx + 1) % 4;
            m_fading = 1'b1;
            m_dwell = 0;
        end else if (!m_fading) begin
            if (tick) begin
                m_dwell++;
                if (m_dwell == DWELL_TICKS) begin
                    m_dwell = 0;
                    m_idx = (m_idx + 1) % 4;
                    m_fading = 1'b1;
                end
            end
        end else if (reached) begin
            m_fading = 1'b0;
        end
        // button: value two edges old, accepted after DEBOUNCE_CYC stable samples
        raw_q.push_front(b);
        if (raw_q.size() > 3) void'(raw_q.pop_back());
        s2 = (raw_q.size() > 2) ? raw_q[2] : 1'b0;
        sync_q.push_front(s2);
        if (sync_q.size() > DEBOUNCE_CYC) void'(sync_q.pop_back());
        np = 1'b0;
        if (sync_q.size() == DEBOUNCE_CYC) begin
            all_diff = 1'b1;
            foreach (sync_q[j]) if (sync_q[j] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                m_level = s2;
                np = s2;
            end
        end
        m_pulse = np;
        m_cyc++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_cyc);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(auto_en, int'(sw), btn_next);
        #1;
        chk("model_R", R_duty, m_r);
        chk("model_G", G_duty, m_g);
        chk("model_B", B_duty, m_b);
        chk("model_idx", preset_idx, m_idx);
        chk("model_busy", busy, m_fading);
    endtask

    typedef struct {
        bit       a;
        bit [1:0] s;
        int       n;
        int       idx;
        bit       bsy;
        int       r, g, b;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_hold, t1, x_exp, k;

        tbl[0]  = '{0, 2'd0, 815, 0, 1, 'h99, 'h32, 'hCB};
        tbl[1]  = '{0, 2'd0,   1, 0, 1, 'h99, 'h32, 'hCC};
        tbl[2]  = '{0, 2'd0,   1, 0, 0, 'h99, 'h32, 'hCC};
        tbl[3]  = '{0, 2'd2,   1, 2, 1, 'h99, 'h32, 'hCC};
        tbl[4]  = '{0, 2'd2, 413, 2, 1, 'hFF, 'h99, 'h65};
        tbl[5]  = '{0, 2'd2, 401, 2, 1, 'hFF, 'hD7, 'h00};
        tbl[6]  = '{0, 2'd2,   1, 2, 0, 'hFF, 'hD7, 'h00};
        tbl[7]  = '{0, 2'd3,   1, 3, 1, 'hFF, 'hD7, 'h00};
        tbl[8]  = '{0, 2'd3, 679, 3, 0, 'hFF, 'h2D, 'h00};
        tbl[9]  = '{1, 2'd1,  30, 3, 0, 'hFF, 'h2D, 'h00};
        tbl[10] = '{1, 2'd1,   1, 0, 1, 'hFF, 'h2D, 'h00};
        tbl[11] = '{1, 2'd1,   4, 0, 1, 'hFE, 'h2E, 'h01};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_R", R_duty, 0);
        chk("reset_G", G_duty, 0);
        chk("reset_B", B_duty, 0);
        chk("reset_idx", preset_idx, 0);
        chk("reset_busy", busy, 1);
        rst = 1'b0;
        model_reset();

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            auto_en = tbl[i].a;
            sw      = tbl[i].s;
            repeat (tbl[i].n) cycle();
            chk($sformatf("vec%0d_R", i), R_duty, tbl[i].r);
            chk($sformatf("vec%0d_G", i), G_duty, tbl[i].g);
            chk($sformatf("vec%0d_B", i), B_duty, tbl[i].b);
            chk($sformatf("vec%0d_idx", i), preset_idx, tbl[i].idx);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
        end

        // auto mode: short glitches rejected, held presses advance once each
        btn_next = 1'b1; cycle();
        btn_next = 1'b0; repeat (8) cycle();
        btn_next = 1'b1; repeat (2) cycle();
        btn_next = 1'b0; repeat (8) cycle();
        chk("glitch_idx", preset_idx, 0);
        btn_next = 1'b1; repeat (10) cycle();
        btn_next = 1'b0; repeat (10) cycle();
        chk("press1_idx", preset_idx, 1);
        btn_next = 1'b1; repeat (10) cycle();
        btn_next = 1'b0; repeat (10) cycle();
        chk("press2_idx", preset_idx, 2);

        // button pulse landing on the dwell-expiry edge advances by one
        k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            cycle();
            k++;
        end
        chk("hold_wait_busy", busy, 0);
        e_hold = m_cyc;
        t1     = ((e_hold / TICK_DIV) + 1) * TICK_DIV;
        x_exp  = t1 + (DWELL_TICKS - 1) * TICK_DIV;
        while (m_cyc < x_exp - 6) cycle();
        btn_next = 1'b1;
        repeat (5) cycle();
        chk("coinc_before_idx", preset_idx, 2);
        repeat (5) cycle();
        btn_next = 1'b0;
        chk("coinc_after_idx", preset_idx, 3);
        repeat (20) cycle();
        chk("coinc_settled_idx", preset_idx, 3);

        // asynchronous reset between edges
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_R", R_duty, 0);
        chk("arst_G", G_duty, 0);
        chk("arst_B", B_duty, 0);
        chk("arst_idx", preset_idx, 0);
        chk("arst_busy", busy, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        auto_en = 1'b0; sw = 2'd0; btn_next = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (3) cycle();
        chk("arst_pretick_R", R_duty, 0);
        cycle();
        chk("arst_tick1_R", R_duty, 1);
        chk("arst_tick1_G", G_duty, 1);
        chk("arst_tick1_B", B_duty, 1);

        // manual retarget mid-fade continues from the current value
        while (m_cyc < 96 * TICK_DIV) cycle();
        chk("mid_R60", R_duty, 'h60);
        sw = 2'd1;
        repeat (4) cycle();
        chk("mid_R5F", R_duty, 'h5F);
        chk("mid_idx", preset_idx, 1);
        btn_next = 1'b1; repeat (10) cycle();
        btn_next = 1'b0; repeat (10) cycle();
        chk("manual_btn_idx", preset_idx, 1);

        // randomized stimulus against the model
        for (int i = 0; i < 400; i++) begin
            int n;
            if ($urandom_range(0, 7) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 3) == 0) sw = 2'($urandom_range(0, 3));
            btn_next = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 12);
            repeat (n) cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
